encoder_arbiter: RTL and testbench



---
 rtl/encoder_arbiter_pkg.sv | 23 ++
 rtl/encoder_arbiter_rr_pick.sv | 34 +++
 rtl/encoder_arbiter.sv | 108 ++++++++++
 tb/tb_encoder_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_arbiter_pkg.sv
// Shared definitions for the encoder arbiter: FSM state encoding, the
// encoder sequence length and the default WAIT timeout.
package encoder_arbiter_pkg;

    // Cycles the encoder controller needs for one conversion sequence.
    localparam int SEQ_CYCLE_COUNT = 16;

    // Default WAIT budget. Leaves margin over SEQ_CYCLE_COUNT for handshake latency.
    localparam int TIMEOUT_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

    // Index arithmetic modulo n, used for the round-robin wrap.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/encoder_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after
// rr_ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
    import encoder_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             found
);

    logic [IW-1:0] k;

    // Scan from rr_ptr; only the first hit is taken.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        k      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IW'(wrap_idx(int'(rr_ptr), i, N_REQ));
            if (!found && req[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = k;
            end
        end
    end

endmodule

// File: rtl/encoder_arbiter.sv
// Arbiter sharing one encoder between N_REQ requesters. A granted requester
// gets one start pulse, then the arbiter waits for encoding_done or times out.
//
// state   | meaning
// S_IDLE  | no owner; evaluates requests when en=1
// S_ISSUE | owner latched; start_encoding pulses
// S_WAIT  | waiting for encoding_done; counter runs while en=1
// S_RESP  | done pulses on the owner; round-robin pointer advances
module encoder_arbiter
    import encoder_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic                       encoding_done,
    input  logic                       clr_err,
    output logic                       start_encoding,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   sel_id,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    arb_state_e      state;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            wait_timeout;
    logic [IW-1:0]   next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // A completion in the same cycle as the last count takes precedence over the timeout.
    assign wait_timeout = (state == S_WAIT) && !encoding_done &&
                          (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign next_ptr     = IW'(wrap_idx(int'(sel_id), 1, N_REQ));

    // Moore outputs decoded from state; done reuses the registered one-hot grant.
    assign start_encoding = (state == S_ISSUE);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_RESP) ? grant : '0;

    // Arbitration FSM, wait counter, round-robin pointer and sticky timeout flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            grant       <= '0;
            sel_id      <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (wait_timeout) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (en && pick_found) begin
                        grant  <= pick_onehot;
                        sel_id <= pick_idx;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (encoding_done || wait_timeout) begin
                        state <= S_RESP;
                    end else if (en) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    rr_ptr <= next_ptr;
                    grant  <= '0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_arbiter.sv
// Self-checking bench for encoder_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_encoder_arbiter;

    localparam int N = 4;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic [3:0] req;
    logic       encoding_done;
    logic       clr_err;
    logic       start_encoding;
    logic [3:0] grant;
    logic [1:0] sel_id;
    logic [3:0] done;
    logic       busy;
    logic       err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr = 0;

    encoder_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .req            (req),
        .encoding_done  (encoding_done),
        .clr_err        (clr_err),
        .start_encoding (start_encoding),
        .grant          (grant),
        .sel_id         (sel_id),
        .done           (done),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (((r >> ((ptr + i) % N)) & 4'd1) != 4'd0) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Drives one transaction from IDLE to the done pulse and reports what was seen.
    // k counts cycles since the start pulse; encoding_done is high during cycle d_at,
    // en is low during cycles [gap_from, gap_from+gap_len), req drops at cycle drop_at.
    task automatic run_txn(input int d_at, input int gap_from, input int gap_len,
                           input int drop_at,
                           output logic [3:0] g, output logic [1:0] s,
                           output int starts, output logic [3:0] d, output int lat);
        int  k;
        bit  started;
        g = '0; s = '0; starts = 0; d = '0; lat = -1; k = 0; started = 0;
        for (int b = 0; b < 200; b++) begin
            tick();
            if (started) k++;
            if (start_encoding) begin
                starts++;
                if (!started) begin
                    started = 1; k = 0; g = grant; s = sel_id;
                end
            end
            if (done != 4'd0) begin
                d = done;
                lat = started ? k : -1;
                break;
            end
            if (started) begin
                encoding_done = (k == d_at);
                en = !(k >= gap_from && k < gap_from + gap_len);
                if (k == drop_at) req = 4'd0;
            end
        end
        encoding_done = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b0; req = '0; encoding_done = 1'b0; clr_err = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (grant !== 4'd0) begin n_errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_checks++; if (sel_id !== 2'd0) begin n_errors++; $display("FAIL reset_sel: got %0d want 0", sel_id); end
        n_checks++; if (start_encoding !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", start_encoding); end
        n_checks++; if (done !== 4'd0) begin n_errors++; $display("FAIL reset_done: got %b want 0000", done); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        nrst = 1'b1;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] g, d, exp_g [5];
        logic [1:0] s;
        int starts, lat;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        req = 4'b1111; en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            run_txn(3, -1, 0, -1, g, s, starts, d, lat);
            n_checks++; if (g !== exp_g[t]) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b want %b", t, g, exp_g[t]); end
            n_checks++; if (d !== exp_g[t] || lat != 4) begin n_errors++; $display("FAIL rr_done[%0d]: got %b at %0d want %b at 4", t, d, lat, exp_g[t]); end
            m_ptr = (pick(4'b1111, m_ptr) + 1) % N;
            if (t == 4) req = 4'd0;
            tick();
            n_checks++; if (busy !== 1'b0 || grant !== 4'd0) begin n_errors++; $display("FAIL rr_idle[%0d]: busy=%b grant=%b want 0/0000", t, busy, grant); end
        end
    endtask

    task automatic test_single();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat;
        req = 4'b0100; en = 1'b1;
        run_txn(10, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (g !== 4'b0100) begin n_errors++; $display("FAIL single_grant: got %b want 0100", g); end
        n_checks++; if (s !== 2'd2) begin n_errors++; $display("FAIL single_sel: got %0d want 2", s); end
        n_checks++; if (starts != 1) begin n_errors++; $display("FAIL single_starts: got %0d want 1", starts); end
        n_checks++; if (d !== 4'b0100 || lat != 11) begin n_errors++; $display("FAIL single_done: got %b at %0d want 0100 at 11", d, lat); end
        m_ptr = 3;
        req = 4'd0;
        tick();
        n_checks++; if (done !== 4'd0) begin n_errors++; $display("FAIL single_done_width: got %b want 0000", done); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_en_low_idle();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat;
        bit bad;
        bad = 0;
        en = 1'b0; req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0 || grant !== 4'd0) bad = 1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL en_low_idle: busy=%b grant=%b want no grant", busy, grant); end
        en = 1'b1;
        run_txn(2, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (g !== 4'b0001 || lat != 3) begin n_errors++; $display("FAIL en_high_grant: got %b at %0d want 0001 at 3", g, lat); end
        m_ptr = 1;
        req = 4'd0;
        tick();
    endtask

    task automatic test_stray_done();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat, w;
        encoding_done = 1'b1; tick();
        encoding_done = 1'b0; tick();
        n_checks++; if (busy !== 1'b0 || grant !== 4'd0 || err_timeout !== 1'b0) begin
            n_errors++; $display("FAIL stray_done: busy=%b grant=%b err=%b want 0/0000/0", busy, grant, err_timeout);
        end
        req = 4'b1001;
        w = pick(req, m_ptr);
        run_txn(4, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (g !== (4'b0001 << w) || lat != 5) begin n_errors++; $display("FAIL stray_next_grant: got %b at %0d want %b at 5", g, lat, 4'b0001 << w); end
        m_ptr = (w + 1) % N;
        req = 4'd0;
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat, w;
        req = 4'b0010;
        w = pick(req, m_ptr);
        clr_err = 1'b1;
        run_txn(-1, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (d !== 4'b0010 || lat != T + 1) begin n_errors++; $display("FAIL timeout_done: got %b at %0d want 0010 at %0d", d, lat, T + 1); end
        n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_set_wins: got %b want 1", err_timeout); end
        m_ptr = (w + 1) % N;
        req = 4'd0;
        tick();
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clr: got %b want 0", err_timeout); end
        clr_err = 1'b0;
        tick();
    endtask

    task automatic test_en_gap();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat, w;
        req = 4'b1000;
        w = pick(req, m_ptr);
        run_txn(-1, 5, 5, -1, g, s, starts, d, lat);
        n_checks++; if (d !== 4'b1000 || lat != T + 1 + 5) begin n_errors++; $display("FAIL en_gap_timeout: got %b at %0d want 1000 at %0d", d, lat, T + 6); end
        m_ptr = (w + 1) % N;
        req = 4'd0;
        tick(); tick(); tick();
        n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", err_timeout); end
        clr_err = 1'b1; tick();
        clr_err = 1'b0;
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b want 0", err_timeout); end
    endtask

    task automatic test_coincident();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat, w;
        req = 4'b0100;
        w = pick(req, m_ptr);
        run_txn(T, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (d !== 4'b0100 || lat != T + 1) begin n_errors++; $display("FAIL coincident_done: got %b at %0d want 0100 at %0d", d, lat, T + 1); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL coincident_err: got %b want 0", err_timeout); end
        m_ptr = (w + 1) % N;
        req = 4'd0;
        tick();
    endtask

    task automatic test_drop();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat, w;
        req = 4'b0100;
        w = pick(req, m_ptr);
        run_txn(8, -1, 0, 3, g, s, starts, d, lat);
        n_checks++; if (d !== 4'b0100 || lat != 9) begin n_errors++; $display("FAIL drop_done: got %b at %0d want 0100 at 9", d, lat); end
        m_ptr = (w + 1) % N;
        tick(); tick();
        n_checks++; if (busy !== 1'b0 || grant !== 4'd0) begin n_errors++; $display("FAIL drop_idle: busy=%b grant=%b want 0/0000", busy, grant); end
    endtask

    task automatic test_random();
        logic [3:0] g, d, r;
        logic [1:0] s;
        int starts, lat, w, dl;
        r = 4'($urandom_range(1, 15));
        req = r; en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            w = pick(r, m_ptr);
            dl = $urandom_range(1, 20);
            run_txn(dl, -1, 0, -1, g, s, starts, d, lat);
            n_checks++;
            if (g !== (4'b0001 << w) || s !== 2'(w) || starts != 1 || d !== (4'b0001 << w) || lat != dl + 1) begin
                n_errors++;
                $display("FAIL random[%0d]: req=%b grant=%b sel=%0d starts=%0d done=%b lat=%0d want grant=%b sel=%0d done lat=%0d",
                         t, r, g, s, starts, d, lat, 4'b0001 << w, w, dl + 1);
            end
            m_ptr = (w + 1) % N;
            r = 4'($urandom_range(1, 15));
            req = r;
            tick();
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL random_idle[%0d]: busy=%b want 0", t, busy); end
        end
        req = 4'd0;
        tick(); tick(); tick(); tick(); tick(); tick();
        for (int i = 0; i < 60 && busy; i++) tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] g, d;
        logic [1:0] s;
        int starts, lat;
        bit bad;
        req = 4'b0010;
        run_txn(2, -1, 0, -1, g, s, starts, d, lat);
        req = 4'b1000;
        tick();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL resetmid_busy_before: got %b want 1", busy); end
        nrst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || grant !== 4'd0 || sel_id !== 2'd0) begin
            n_errors++; $display("FAIL resetmid_async: busy=%b grant=%b sel=%0d want 0/0000/0", busy, grant, sel_id);
        end
        n_checks++; if (start_encoding !== 1'b0 || done !== 4'd0 || err_timeout !== 1'b0) begin
            n_errors++; $display("FAIL resetmid_outs: start=%b done=%b err=%b want 0", start_encoding, done, err_timeout);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 4'd0) bad = 1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL resetmid_no_done: done pulsed during reset"); end
        req = 4'b1010;
        nrst = 1'b1;
        m_ptr = 0;
        run_txn(2, -1, 0, -1, g, s, starts, d, lat);
        n_checks++; if (g !== 4'b0010 || s !== 2'd1) begin n_errors++; $display("FAIL resetmid_regrant: got %b sel=%0d want 0010 sel=1", g, s); end
        bad = 0;
        tick();
        req = 4'd0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_en_low_idle();
        test_stray_done();
        test_timeout();
        test_en_gap();
        test_coincident();
        test_drop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
